// File: rtl/state_hash_gen_matrix_pkg.sv
// Shared sizes, state encodings and the XOF input packing for the Kyber matrix-A sequencer.
// Pure definitions; no logic, no latency.
package state_hash_gen_matrix_pkg;

  localparam int KYBER_K      = 2;
  localparam int KYBER_N      = 256;
  localparam int KYBER_Q      = 3329;
  localparam int SEED_BITS    = 256;
  localparam int XOF_IN_BITS  = SEED_BITS + 16;
  localparam int XOF_OUT_BITS = 5376;
  localparam int POLY_BITS    = 16 * KYBER_N;
  localparam int SLOTS        = KYBER_K * KYBER_K;
  localparam int MATRIX_BITS  = SLOTS * POLY_BITS;
  localparam int IDX_W        = (KYBER_K > 1) ? $clog2(KYBER_K) : 1;
  localparam int SLOT_W       = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_XOF_CLR  = 3'd1;
  localparam logic [2:0] S_XOF_GO   = 3'd2;
  localparam logic [2:0] S_XOF_WAIT = 3'd3;
  localparam logic [2:0] S_REJ_CLR  = 3'd4;
  localparam logic [2:0] S_REJ_GO   = 3'd5;
  localparam logic [2:0] S_REJ_WAIT = 3'd6;
  localparam logic [2:0] S_STORE    = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE     = S_IDLE,
    ST_XOF_CLR  = S_XOF_CLR,
    ST_XOF_GO   = S_XOF_GO,
    ST_XOF_WAIT = S_XOF_WAIT,
    ST_REJ_CLR  = S_REJ_CLR,
    ST_REJ_GO   = S_REJ_GO,
    ST_REJ_WAIT = S_REJ_WAIT,
    ST_STORE    = S_STORE
  } state_t;

  function automatic logic [XOF_IN_BITS-1:0] xof_input(input logic [SEED_BITS-1:0] seed,
                                                       input logic [7:0] b32,
                                                       input logic [7:0] b33);
    return {seed, b32, b33};
  endfunction

endpackage

// File: rtl/state_hash_gen_matrix_if.sv
// Bundles control, XOF and sampler handshakes plus the matrix result of the sequencer.
// master = environment side, slave = the sequencer.
interface state_hash_gen_matrix_if;
  import state_hash_gen_matrix_pkg::*;

  logic                    clear;
  logic                    enable;
  logic                    transposed;
  logic [SEED_BITS-1:0]    i_Seed;
  logic                    o_Xof_Clear;
  logic                    o_Xof_Enable;
  logic [XOF_IN_BITS-1:0]  o_Xof_Input;
  logic                    i_Xof_Done;
  logic [XOF_OUT_BITS-1:0] i_Xof_Output;
  logic                    o_Rej_Clear;
  logic                    o_Rej_Enable;
  logic [XOF_OUT_BITS-1:0] o_Rej_CharArray;
  logic                    i_Rej_Done;
  logic [POLY_BITS-1:0]    i_Rej_Poly;
  logic [MATRIX_BITS-1:0]  oMatrix;
  logic                    Gen_Matrix_done;

  modport master (
    output clear, enable, transposed, i_Seed,
    output i_Xof_Done, i_Xof_Output, i_Rej_Done, i_Rej_Poly,
    input  o_Xof_Clear, o_Xof_Enable, o_Xof_Input,
    input  o_Rej_Clear, o_Rej_Enable, o_Rej_CharArray,
    input  oMatrix, Gen_Matrix_done
  );

  modport slave (
    input  clear, enable, transposed, i_Seed,
    input  i_Xof_Done, i_Xof_Output, i_Rej_Done, i_Rej_Poly,
    output o_Xof_Clear, o_Xof_Enable, o_Xof_Input,
    output o_Rej_Clear, o_Rej_Enable, o_Rej_CharArray,
    output oMatrix, Gen_Matrix_done
  );

endinterface

// File: rtl/state_hash_matrix_index.sv
// Row/column walker over the KxK matrix; col advances fastest, row on col wrap.
// Zeroed by i_zero (priority over i_adv); index bytes swap order when i_transposed.
module state_hash_matrix_index
  import state_hash_gen_matrix_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_zero,
  input  logic             i_adv,
  input  logic             i_transposed,
  output logic [IDX_W-1:0] o_row,
  output logic [IDX_W-1:0] o_col,
  output logic             o_last,
  output logic [7:0]       o_byte32,
  output logic [7:0]       o_byte33
);

  logic [IDX_W-1:0] r_row;
  logic [IDX_W-1:0] r_col;
  logic             w_col_wrap;
  logic             w_row_wrap;

  assign w_col_wrap = (r_col == IDX_W'(KYBER_K - 1));
  assign w_row_wrap = (r_row == IDX_W'(KYBER_K - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_zero) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_adv) begin
      if (w_col_wrap) begin
        r_col <= '0;
        r_row <= w_row_wrap ? '0 : r_row + IDX_W'(1);
      end else begin
        r_col <= r_col + IDX_W'(1);
      end
    end
  end

  assign o_row    = r_row;
  assign o_col    = r_col;
  assign o_last   = w_col_wrap && w_row_wrap;
  // Normal order feeds seed||j||i, i.e. column byte first.
  assign o_byte32 = i_transposed ? 8'(r_row) : 8'(r_col);
  assign o_byte33 = i_transposed ? 8'(r_col) : 8'(r_row);

endmodule

// File: rtl/state_hash_gen_matrix.sv
// Builds Kyber matrix A: per entry, XOF on seed||idx, latch squeeze, run rejection sampler, store poly.
// 6 cycles overhead per entry plus XOF and sampler time; WAIT states hold indefinitely.
module state_hash_gen_matrix
  import state_hash_gen_matrix_pkg::*;
(
  input logic                   clk,
  input logic                   reset_n,
  state_hash_gen_matrix_if.slave bus
);

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_xof_armed;
  logic [XOF_IN_BITS-1:0]  r_xof_input;
  logic [XOF_OUT_BITS-1:0] r_char;
  logic [MATRIX_BITS-1:0]  r_matrix;
  logic                    r_done;

  logic                    w_start;
  logic                    w_store;
  logic                    w_latch;
  logic                    w_last;
  logic [IDX_W-1:0]        w_row;
  logic [IDX_W-1:0]        w_col;
  logic [7:0]              w_byte32;
  logic [7:0]              w_byte33;
  logic [SLOT_W-1:0]       w_slot;
  logic                    w_xof_clr;
  logic                    w_xof_go;
  logic                    w_rej_clr;
  logic                    w_rej_go;

  assign w_start = (r_state == ST_IDLE) && bus.enable;
  assign w_store = (r_state == ST_STORE);
  assign w_latch = (r_state == ST_XOF_WAIT) && r_xof_armed && bus.i_Xof_Done;
  assign w_slot  = SLOT_W'(w_row) * SLOT_W'(KYBER_K) + SLOT_W'(w_col);

  state_hash_matrix_index u_index (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_zero       (bus.clear || w_start),
    .i_adv        (w_store),
    .i_transposed (bus.transposed),
    .o_row        (w_row),
    .o_col        (w_col),
    .o_last       (w_last),
    .o_byte32     (w_byte32),
    .o_byte33     (w_byte33)
  );

  always_comb begin
    w_next    = r_state;
    w_xof_clr = 1'b0;
    w_xof_go  = 1'b0;
    w_rej_clr = 1'b0;
    w_rej_go  = 1'b0;
    unique case (r_state)
      ST_IDLE:     if (bus.enable) w_next = ST_XOF_CLR;
      ST_XOF_CLR:  begin w_next = ST_XOF_GO;   w_xof_clr = 1'b1; end
      ST_XOF_GO:   begin w_next = ST_XOF_WAIT; w_xof_go  = 1'b1; end
      ST_XOF_WAIT: if (w_latch) w_next = ST_REJ_CLR;
      ST_REJ_CLR:  begin w_next = ST_REJ_GO;   w_rej_clr = 1'b1; end
      ST_REJ_GO:   begin w_next = ST_REJ_WAIT; w_rej_go  = 1'b1; end
      ST_REJ_WAIT: if (bus.i_Rej_Done) w_next = ST_STORE;
      ST_STORE:    w_next = w_last ? ST_IDLE : ST_XOF_CLR;
      default:     w_next = ST_IDLE;
    endcase
    // An abort must silence strobes in the very cycle it is raised.
    if (bus.clear) begin
      w_xof_clr = 1'b0;
      w_xof_go  = 1'b0;
      w_rej_clr = 1'b0;
      w_rej_go  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_xof_armed <= 1'b0;
      r_xof_input <= '0;
      r_char      <= '0;
      r_matrix    <= '0;
      r_done      <= 1'b0;
    end else if (bus.clear) begin
      r_state     <= ST_IDLE;
      r_xof_armed <= 1'b0;
      r_xof_input <= '0;
      r_char      <= '0;
      r_matrix    <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next;
      // Low on the first XOF_WAIT cycle so a done level left from the last run is ignored.
      r_xof_armed <= (r_state == ST_XOF_WAIT);
      if (w_start) r_done <= 1'b0;
      if (r_state == ST_XOF_CLR) r_xof_input <= xof_input(bus.i_Seed, w_byte32, w_byte33);
      if (w_latch) r_char <= bus.i_Xof_Output;
      if (w_store) begin
        for (int s = 0; s < SLOTS; s++) begin
          if (w_slot == SLOT_W'(s)) r_matrix[MATRIX_BITS-1-s*POLY_BITS -: POLY_BITS] <= bus.i_Rej_Poly;
        end
        if (w_last) r_done <= 1'b1;
      end
    end
  end

  assign bus.o_Xof_Clear     = w_xof_clr;
  assign bus.o_Xof_Enable    = w_xof_go;
  assign bus.o_Xof_Input     = r_xof_input;
  assign bus.o_Rej_Clear     = w_rej_clr;
  assign bus.o_Rej_Enable    = w_rej_go;
  assign bus.o_Rej_CharArray = r_char;
  assign bus.oMatrix         = r_matrix;
  assign bus.Gen_Matrix_done = r_done;

endmodule

// File: tb/tb_state_hash_gen_matrix.sv
// Directed bench for the matrix-A sequencer with in-bench XOF (5-cycle) and sampler (10-cycle) stubs.
module tb_state_hash_gen_matrix;
  import state_hash_gen_matrix_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  state_hash_gen_matrix_if bus();

  state_hash_gen_matrix dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // stub state
  bit                      stale_keep = 1'b0;
  bit                      xof_busy = 1'b0;
  int                      xof_cnt = 0;
  int                      xof_run = 0;
  logic [XOF_OUT_BITS-1:0] xof_good = '0;
  bit                      rej_busy = 1'b0;
  int                      rej_cnt = 0;
  int                      rej_run = 0;
  bit                      rej_cleared = 1'b0;
  logic [XOF_OUT_BITS-1:0] rej_snap = '0;

  // monitor state
  int         exp_id = 0;
  logic [3:0] prev_strb = 4'd0;
  int         xe_cyc = 0;
  int         strobe_cnt = 0;
  int         done_rises = 0;
  logic       prev_done = 1'b0;
  logic [15:0] xin_q[$];
  logic [SEED_BITS-1:0] seed;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wide(input string tag, input logic [MATRIX_BITS-1:0] obs, input logic [MATRIX_BITS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed_lo=%h expected_lo=%h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  function automatic logic [XOF_OUT_BITS-1:0] pat(input int r);
    return {(XOF_OUT_BITS/32){32'hA5000000 + 32'(r)}};
  endfunction

  // One cycle: sample at the falling edge, check strobes, then advance the stubs.
  task automatic tick();
    logic [3:0] s;
    int id;
    @(negedge clk);
    cyc++;
    s = {bus.o_Xof_Clear, bus.o_Xof_Enable, bus.o_Rej_Clear, bus.o_Rej_Enable};
    if (s != 4'd0) begin
      strobe_cnt++;
      id = s[3] ? 0 : s[2] ? 1 : s[1] ? 2 : 3;
      chk("strobe_onehot", 64'($countones(s)), 64'd1);
      chk("strobe_order", 64'(id), 64'(exp_id));
      chk("strobe_width", 64'(prev_strb & s), 64'd0);
      exp_id = (id + 1) % 4;
      if (s[2]) begin
        xin_q.push_back(bus.o_Xof_Input[15:0]);
        chk_wide("xof_seed", MATRIX_BITS'(bus.o_Xof_Input[XOF_IN_BITS-1:16]), MATRIX_BITS'(seed));
        xe_cyc = cyc;
      end
      if (s[1]) chk("xof_wait_gap", 64'(cyc - xe_cyc), stale_keep ? 64'd3 : 64'd6);
    end
    prev_strb = s;
    if (bus.Gen_Matrix_done && !prev_done) done_rises++;
    prev_done = bus.Gen_Matrix_done;

    if (!reset_n || bus.clear) begin
      bus.i_Xof_Done = 1'b0; xof_busy = 1'b0; xof_cnt = 0;
      bus.i_Rej_Done = 1'b0; rej_busy = 1'b0; rej_cnt = 0; rej_run = 0; rej_cleared = 1'b0;
      exp_id = 0;
    end else begin
      if (s[3] && !stale_keep) bus.i_Xof_Done = 1'b0;
      if (s[2] && !stale_keep) begin
        xof_busy = 1'b1; xof_cnt = 0;
      end else if (xof_busy) begin
        xof_cnt++;
        if (xof_cnt == 5) begin
          xof_good = pat(xof_run);
          xof_run++;
          bus.i_Xof_Output = xof_good;
          bus.i_Xof_Done = 1'b1;
          xof_busy = 1'b0;
        end
      end
      if (s[1]) begin
        bus.i_Rej_Done = 1'b0; rej_cleared = 1'b1;
      end
      if (s[0]) begin
        chk("rej_clear_first", 64'(rej_cleared), 64'd1);
        chk_wide("char_at_go", MATRIX_BITS'(bus.o_Rej_CharArray), MATRIX_BITS'(xof_good));
        rej_snap = bus.o_Rej_CharArray;
        rej_busy = 1'b1; rej_cnt = 0; rej_cleared = 1'b0;
        bus.i_Xof_Output = ~xof_good;
      end else if (rej_busy) begin
        rej_cnt++;
        chk_wide("char_stable", MATRIX_BITS'(bus.o_Rej_CharArray), MATRIX_BITS'(rej_snap));
        if (rej_cnt == 10) begin
          bus.i_Rej_Poly = {KYBER_N{16'(rej_run)}};
          bus.i_Rej_Done = 1'b1;
          rej_busy = 1'b0;
          rej_run = (rej_run + 1) % 4;
          bus.i_Xof_Output = xof_good;
        end
      end
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_strobes"}, 64'({bus.o_Xof_Clear, bus.o_Xof_Enable, bus.o_Rej_Clear, bus.o_Rej_Enable}), 64'd0);
    chk({tag, "_done"}, 64'(bus.Gen_Matrix_done), 64'd0);
    chk_wide({tag, "_matrix"}, bus.oMatrix, '0);
    chk_wide({tag, "_char"}, MATRIX_BITS'(bus.o_Rej_CharArray), '0);
    chk_wide({tag, "_xofin"}, MATRIX_BITS'(bus.o_Xof_Input), '0);
  endtask

  task automatic run_matrix(input logic tr, input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3, input bit poke);
    logic [15:0] e [4];
    int n;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    xin_q.delete();
    done_rises = 0;
    bus.transposed = tr;
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    chk("done_low_after_start", 64'(bus.Gen_Matrix_done), 64'd0);
    n = 0;
    while (!bus.Gen_Matrix_done && n < 3000) begin
      tick();
      n++;
      if (poke && n == 20) begin
        bus.enable = 1'b1;
        tick();
        bus.enable = 1'b0;
      end
    end
    chk("done_reached", 64'(bus.Gen_Matrix_done), 64'd1);
    repeat (10) tick();
    chk("done_sticky", 64'(bus.Gen_Matrix_done), 64'd1);
    chk("done_rises_once", 64'(done_rises), 64'd1);
    chk("xof_runs", 64'(xin_q.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      chk("xof_idx_bytes", 64'((k < xin_q.size()) ? xin_q[k] : 16'hFFFF), 64'(e[k]));
    for (int s = 0; s < SLOTS; s++)
      chk_wide("slot_poly", MATRIX_BITS'(bus.oMatrix[MATRIX_BITS-1-s*POLY_BITS -: POLY_BITS]),
               MATRIX_BITS'({KYBER_N{16'(s)}}));
  endtask

  initial begin
    int n;
    int sc;
    for (int i = 0; i < 32; i++) seed[SEED_BITS-1-8*i -: 8] = 8'(i);
    reset_n = 1'b0;
    bus.clear = 1'b0;
    bus.enable = 1'b0;
    bus.transposed = 1'b0;
    bus.i_Seed = seed;
    bus.i_Xof_Done = 1'b0;
    bus.i_Xof_Output = '0;
    bus.i_Rej_Done = 1'b0;
    bus.i_Rej_Poly = '0;

    repeat (3) tick();
    chk_zero_outputs("reset");
    reset_n = 1'b1;
    tick();

    run_matrix(1'b0, 16'h0000, 16'h0100, 16'h0001, 16'h0101, 1'b0);
    run_matrix(1'b1, 16'h0000, 16'h0001, 16'h0100, 16'h0101, 1'b1);

    stale_keep = 1'b1;
    run_matrix(1'b0, 16'h0000, 16'h0100, 16'h0001, 16'h0101, 1'b0);
    stale_keep = 1'b0;

    // abort inside the sampler wait of slot 2
    bus.transposed = 1'b0;
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    n = 0;
    while (!(rej_busy && rej_run == 2) && n < 3000) begin
      tick();
      n++;
    end
    chk("reached_slot2_wait", 64'(rej_busy && rej_run == 2), 64'd1);
    tick();
    bus.clear = 1'b1;
    tick();
    chk("no_strobe_in_clear", 64'(prev_strb), 64'd0);
    bus.clear = 1'b0;
    tick();
    chk_zero_outputs("clear");
    sc = strobe_cnt;
    repeat (20) tick();
    chk("idle_after_clear", 64'(strobe_cnt - sc), 64'd0);
    run_matrix(1'b0, 16'h0000, 16'h0100, 16'h0001, 16'h0101, 1'b0);

    // asynchronous reset mid-run
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    repeat (15) tick();
    reset_n = 1'b0;
    tick();
    chk_zero_outputs("midrun_reset");
    reset_n = 1'b1;
    sc = strobe_cnt;
    repeat (10) tick();
    chk("idle_after_reset", 64'(strobe_cnt - sc), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
